// File: rtl/channel_config_sequencer_pkg.sv
// Shared definitions for the channel configuration sequencer: FSM encoding,
// radio command addresses and the FSCTRL frequency word helpers.
package channel_config_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_NEXT      = 3'd3,
        ST_FINISH    = 3'd4
    } seq_state_t;

    localparam logic [5:0] ADDR_SRFOFF  = 6'h06;
    localparam logic [5:0] ADDR_SRXON   = 6'h03;
    localparam logic [5:0] ADDR_FSCTRL  = 6'h18;
    localparam logic [5:0] FSCTRL_UPPER = 6'b010000;
    localparam logic [9:0] FREQ_STEP    = 10'd5;

    // Command slots: 0 = SRFOFF, 1 = FSCTRL write, 2 = SRXON (last)
    localparam int         NUM_CMD_SLOTS = 4;
    localparam logic [1:0] LAST_CMD      = 2'd2;

    typedef struct packed {
        logic        is_strobe;
        logic [5:0]  addr;
        logic [15:0] data;
    } radio_cmd_t;

    function automatic logic [9:0] calc_freq(input logic [9:0] base, input logic [3:0] channel);
        return base + FREQ_STEP * {6'd0, channel};
    endfunction

    function automatic radio_cmd_t build_cmd(input int idx, input logic [9:0] freq);
        radio_cmd_t cmd;
        cmd.is_strobe = 1'b1;
        cmd.addr      = ADDR_SRXON;
        cmd.data      = 16'h0000;
        if (idx == 0) begin
            cmd.addr = ADDR_SRFOFF;
        end else if (idx == 1) begin
            cmd.is_strobe = 1'b0;
            cmd.addr      = ADDR_FSCTRL;
            cmd.data      = {FSCTRL_UPPER, freq};
        end
        return cmd;
    endfunction

endpackage

// File: rtl/channel_config_sequencer_radio_cmd_issuer.sv
// Radio command port handshake: presents a command while start is high,
// reports acceptance, then watches for completion or timeout while wait_en is high.
module radio_cmd_issuer
    import channel_config_sequencer_pkg::*;
#(
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        srst,
    input  logic        start,
    input  logic        wait_en,
    input  logic        cmd_is_strobe,
    input  logic [5:0]  cmd_addr,
    input  logic [15:0] cmd_data,
    input  logic        cmd_ready,
    input  logic        cmd_done,
    output logic        cmd_valid,
    output logic        cmd_is_strobe_out,
    output logic [5:0]  cmd_addr_out,
    output logic [15:0] cmd_data_out,
    output logic        accepted,
    output logic        done_hit,
    output logic        timeout_hit
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] wait_cnt_reg;

    // Counter sits at zero outside the wait phase, so its first wait cycle is cycle 1 after acceptance
    always_ff @(posedge clk) begin
        if (srst || !wait_en) begin
            wait_cnt_reg <= '0;
        end else begin
            wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
        end
    end

    assign cmd_valid         = start;
    assign cmd_is_strobe_out = start & cmd_is_strobe;
    assign cmd_addr_out      = start ? cmd_addr : 6'h00;
    assign cmd_data_out      = start ? cmd_data : 16'h0000;

    assign accepted    = start & cmd_ready;
    assign done_hit    = wait_en & cmd_done;
    // A completion arriving on the last allowed cycle still wins over the timeout
    assign timeout_hit = wait_en & ~cmd_done & (wait_cnt_reg == CNT_LAST);

endmodule

// File: rtl/channel_config_sequencer.sv
// Retunes the radio on a channel-change request: SRFOFF strobe, FSCTRL write
// with the channel frequency, SRXON strobe, then a one-cycle done pulse.
module channel_config_sequencer
    import channel_config_sequencer_pkg::*;
#(
    parameter int TIMEOUT   = 1023,
    parameter int FREQ_BASE = 357
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        ChannelChange,
    input  logic [3:0]  Channel,
    output logic        ChannelChange_done,
    output logic        Busy,
    output logic        Error,
    output logic        Cmd_valid,
    output logic        Cmd_isStrobe,
    output logic [5:0]  Cmd_addr,
    output logic [15:0] Cmd_data,
    input  logic        Cmd_ready,
    input  logic        Cmd_done
);

    localparam logic [9:0] FREQ_BASE_CODE = 10'(FREQ_BASE);

    seq_state_t state_reg, state_next;
    logic [1:0] cmd_idx_reg, cmd_idx_next;
    logic [3:0] channel_reg, channel_next;
    logic       pending_reg, pending_next;
    logic       error_reg, error_next;
    logic       cc_prev_reg;
    logic       cc_armed_reg;

    logic       cc_rise;
    logic       issue_en;
    logic       wait_en;
    logic       accepted;
    logic       done_hit;
    logic       timeout_hit;
    logic [9:0] freq;
    radio_cmd_t cmd_table [NUM_CMD_SLOTS];
    radio_cmd_t cur_cmd;

    // Armed only after ChannelChange has been seen low, so a level held through reset cannot start a sequence
    assign cc_rise = ChannelChange & ~cc_prev_reg & cc_armed_reg;

    assign freq = calc_freq(FREQ_BASE_CODE, channel_reg);

    generate
        for (genvar gi = 0; gi < NUM_CMD_SLOTS; gi++) begin : g_cmd_table
            assign cmd_table[gi] = build_cmd(gi, freq);
        end
    endgenerate

    assign cur_cmd = cmd_table[cmd_idx_reg];

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg    <= ST_IDLE;
            cmd_idx_reg  <= 2'd0;
            channel_reg  <= 4'd0;
            pending_reg  <= 1'b0;
            error_reg    <= 1'b0;
            cc_prev_reg  <= 1'b0;
            cc_armed_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cmd_idx_reg  <= cmd_idx_next;
            channel_reg  <= channel_next;
            pending_reg  <= pending_next;
            error_reg    <= error_next;
            cc_prev_reg  <= ChannelChange;
            cc_armed_reg <= cc_armed_reg | ~ChannelChange;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cmd_idx_next = cmd_idx_reg;
        channel_next = channel_reg;
        pending_next = pending_reg;
        error_next   = error_reg;
        issue_en     = 1'b0;
        wait_en      = 1'b0;

        // Requests arriving while busy (including the FINISH cycle) are queued
        if (cc_rise && (state_reg != ST_IDLE)) begin
            pending_next = 1'b1;
        end

        case (state_reg)
            ST_IDLE: begin
                if (cc_rise || pending_reg) begin
                    channel_next = Channel;
                    cmd_idx_next = 2'd0;
                    pending_next = 1'b0;
                    state_next   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                issue_en = 1'b1;
                if (accepted) begin
                    state_next = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                wait_en = 1'b1;
                if (done_hit) begin
                    state_next = ST_NEXT;
                end else if (timeout_hit) begin
                    error_next = 1'b1;
                    state_next = ST_FINISH;
                end
            end
            ST_NEXT: begin
                if (cmd_idx_reg == LAST_CMD) begin
                    error_next = 1'b0;
                    state_next = ST_FINISH;
                end else begin
                    cmd_idx_next = cmd_idx_reg + 2'd1;
                    state_next   = ST_ISSUE;
                end
            end
            ST_FINISH: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    radio_cmd_issuer #(
        .TIMEOUT (TIMEOUT)
    ) u_issuer (
        .clk               (Clock),
        .srst              (Reset),
        .start             (issue_en),
        .wait_en           (wait_en),
        .cmd_is_strobe     (cur_cmd.is_strobe),
        .cmd_addr          (cur_cmd.addr),
        .cmd_data          (cur_cmd.data),
        .cmd_ready         (Cmd_ready),
        .cmd_done          (Cmd_done),
        .cmd_valid         (Cmd_valid),
        .cmd_is_strobe_out (Cmd_isStrobe),
        .cmd_addr_out      (Cmd_addr),
        .cmd_data_out      (Cmd_data),
        .accepted          (accepted),
        .done_hit          (done_hit),
        .timeout_hit       (timeout_hit)
    );

    assign Busy               = (state_reg != ST_IDLE);
    assign ChannelChange_done = (state_reg == ST_FINISH);
    assign Error              = error_reg;

endmodule

// File: tb/tb_channel_config_sequencer.sv
// Directed bench for channel_config_sequencer with a simple radio port responder
// (ready one cycle after valid, done one cycle after acceptance).
module tb_channel_config_sequencer;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        ChannelChange;
    logic [3:0]  Channel;
    logic        ChannelChange_done;
    logic        Busy;
    logic        Error;
    logic        Cmd_valid;
    logic        Cmd_isStrobe;
    logic [5:0]  Cmd_addr;
    logic [15:0] Cmd_data;
    logic        Cmd_ready;
    logic        Cmd_done;

    int n_checks = 0;
    int n_errors = 0;
    int tick_no = 0;
    int done_pulses = 0;
    int last_done_tick = 0;
    int fsctrl_acc_tick = 0;
    int seq_start_tick = 0;
    logic auto_ready;
    logic auto_done;
    logic withhold_en;
    logic [22:0] cmd_log [$];

    // Start edge to done pulse: 1 edge out of IDLE + 3 x (ISSUE 2 + WAIT_DONE 1 + NEXT 1)
    localparam int SEQ_LATENCY = 1 + 3 * 4;

    channel_config_sequencer #(
        .TIMEOUT   (16),
        .FREQ_BASE (357)
    ) dut (
        .Clock              (Clock),
        .Reset              (Reset),
        .ChannelChange      (ChannelChange),
        .Channel            (Channel),
        .ChannelChange_done (ChannelChange_done),
        .Busy               (Busy),
        .Error              (Error),
        .Cmd_valid          (Cmd_valid),
        .Cmd_isStrobe       (Cmd_isStrobe),
        .Cmd_addr           (Cmd_addr),
        .Cmd_data           (Cmd_data),
        .Cmd_ready          (Cmd_ready),
        .Cmd_done           (Cmd_done)
    );

    always #5 Clock = ~Clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [26:0] outs();
        return {Cmd_valid, Cmd_isStrobe, Cmd_addr, Cmd_data, ChannelChange_done, Busy, Error};
    endfunction

    function automatic logic [22:0] log_at(input int i);
        if (i < cmd_log.size()) return cmd_log[i];
        return '1;
    endfunction

    // One clock: log acceptances, then respond as the radio would after the edge
    task automatic tick();
        logic acc;
        logic pre_valid;
        logic [22:0] word;
        acc = Cmd_valid && Cmd_ready;
        pre_valid = Cmd_valid;
        word = {Cmd_isStrobe, Cmd_addr, Cmd_data};
        if (acc) begin
            cmd_log.push_back(word);
            $display("t=%0d cmd strobe=%0b addr=%h data=%h", tick_no, word[22], word[21:16], word[15:0]);
        end
        @(posedge Clock);
        #1;
        tick_no++;
        if (acc && (word[21:16] == 6'h18)) fsctrl_acc_tick = tick_no;
        Cmd_ready = auto_ready && pre_valid && !acc;
        Cmd_done  = acc && auto_done && !(withhold_en && (word[21:16] == 6'h18));
        if (ChannelChange_done) begin
            done_pulses++;
            last_done_tick = tick_no;
        end
    endtask

    task automatic start_seq(input logic [3:0] ch);
        ChannelChange = 1'b0;
        tick();
        Channel = ch;
        ChannelChange = 1'b1;
        seq_start_tick = tick_no;
    endtask

    task automatic wait_for_done(input string tag, input int budget);
        int start_cnt;
        int n;
        start_cnt = done_pulses;
        n = 0;
        while ((done_pulses == start_cnt) && (n < budget)) begin
            tick();
            n++;
        end
        check_eq({tag, "_done_seen"}, 32'(done_pulses != start_cnt), 1);
    endtask

    task automatic run_plain(input string tag, input logic [3:0] ch, input logic [15:0] exp_data);
        cmd_log.delete();
        start_seq(ch);
        wait_for_done(tag, 100);
        check_eq({tag, "_error"}, Error, 0);
        check_eq({tag, "_fsctrl"}, log_at(1), {1'b0, 6'h18, exp_data});
    endtask

    task automatic run_timeout(input string tag);
        int d0;
        withhold_en = 1'b1;
        cmd_log.delete();
        d0 = done_pulses;
        start_seq(4'd7);
        wait_for_done(tag, 200);
        check_eq({tag, "_wait_cycles"}, last_done_tick - fsctrl_acc_tick, 16);
        check_eq({tag, "_error"}, Error, 1);
        repeat (5) tick();
        check_eq({tag, "_ncmd"}, cmd_log.size(), 2);
        check_eq({tag, "_one_done"}, done_pulses - d0, 1);
        check_eq({tag, "_sticky"}, Error, 1);
        withhold_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int n;
        int stable_bad;
        logic [22:0] snap;

        Reset = 1'b1;
        ChannelChange = 1'b0;
        Channel = 4'd0;
        Cmd_ready = 1'b0;
        Cmd_done = 1'b0;
        auto_ready = 1'b1;
        auto_done = 1'b1;
        withhold_en = 1'b0;
        repeat (3) tick();
        check_eq("reset_outs", 32'(outs()), 0);
        Reset = 1'b0;
        tick();
        check_eq("idle_outs", 32'(outs()), 0);

        // Channel 9 with a late Channel change that must be ignored
        cmd_log.delete();
        d0 = done_pulses;
        start_seq(4'd9);
        tick();
        check_eq("ch9_busy", Busy, 1);
        Channel = 4'hF;
        wait_for_done("ch9", 100);
        check_eq("ch9_latency", last_done_tick - seq_start_tick, SEQ_LATENCY);
        check_eq("ch9_error", Error, 0);
        check_eq("ch9_ncmd", cmd_log.size(), 3);
        check_eq("ch9_cmd0", log_at(0), {1'b1, 6'h06, 16'h0000});
        check_eq("ch9_cmd1", log_at(1), {1'b0, 6'h18, 16'h4192});
        check_eq("ch9_cmd2", log_at(2), {1'b1, 6'h03, 16'h0000});
        repeat (3) tick();
        check_eq("ch9_one_done", done_pulses - d0, 1);
        check_eq("ch9_idle", Busy, 0);

        // Ready stalled 50 cycles, with a stray Cmd_done in the middle
        cmd_log.delete();
        auto_ready = 1'b0;
        start_seq(4'd5);
        n = 0;
        while (!Cmd_valid && (n < 10)) begin
            tick();
            n++;
        end
        check_eq("stall_valid_seen", Cmd_valid, 1);
        snap = {Cmd_isStrobe, Cmd_addr, Cmd_data};
        check_eq("stall_fields", snap, {1'b1, 6'h06, 16'h0000});
        stable_bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (i == 10) Cmd_done = 1'b1;
            tick();
            if (!Cmd_valid || ({Cmd_isStrobe, Cmd_addr, Cmd_data} != snap)) stable_bad++;
        end
        check_eq("stall_stable_cycles", stable_bad, 0);
        check_eq("stall_no_error", Error, 0);
        check_eq("stall_no_accept", cmd_log.size(), 0);
        auto_ready = 1'b1;
        wait_for_done("stall", 100);
        check_eq("stall_fsctrl", log_at(1), {1'b0, 6'h18, 16'h417E});
        check_eq("stall_ncmd", cmd_log.size(), 3);

        // Second request mid-sequence is queued and uses Channel at restart
        cmd_log.delete();
        d0 = done_pulses;
        start_seq(4'd9);
        repeat (3) tick();
        ChannelChange = 1'b0;
        tick();
        Channel = 4'd3;
        ChannelChange = 1'b1;
        wait_for_done("pend_first", 100);
        wait_for_done("pend_second", 100);
        check_eq("pend_ncmd", cmd_log.size(), 6);
        check_eq("pend_first_fsctrl", log_at(1), {1'b0, 6'h18, 16'h4192});
        check_eq("pend_second_fsctrl", log_at(4), {1'b0, 6'h18, 16'h4174});
        check_eq("pend_two_done", done_pulses - d0, 2);

        // Rising edge landing in the FINISH cycle; also channel 0 and 15
        cmd_log.delete();
        d0 = done_pulses;
        start_seq(4'd0);
        tick();
        ChannelChange = 1'b0;
        wait_for_done("fin_first", 100);
        Channel = 4'd15;
        ChannelChange = 1'b1;
        wait_for_done("fin_second", 100);
        check_eq("fin_ch0_fsctrl", log_at(1), {1'b0, 6'h18, 16'h4165});
        check_eq("fin_ch15_fsctrl", log_at(4), {1'b0, 6'h18, 16'h41B0});
        check_eq("fin_two_done", done_pulses - d0, 2);

        // Timeout on FSCTRL, then a successful sequence clears Error
        run_timeout("to1");
        run_plain("after_to", 4'd3, 16'h4174);

        // Reset while waiting for done, with ChannelChange held high
        run_timeout("to2");
        auto_done = 1'b0;
        cmd_log.delete();
        d0 = done_pulses;
        start_seq(4'd9);
        n = 0;
        while ((cmd_log.size() == 0) && (n < 20)) begin
            tick();
            n++;
        end
        check_eq("rst_in_wait", {Busy, Cmd_valid}, 2'b10);
        Reset = 1'b1;
        tick();
        check_eq("rst_outs", 32'(outs()), 0);
        Reset = 1'b0;
        auto_done = 1'b1;
        repeat (20) tick();
        check_eq("rst_no_done", done_pulses - d0, 0);
        check_eq("rst_no_restart", cmd_log.size(), 1);
        check_eq("rst_idle", Busy, 0);
        run_plain("post_rst", 4'd3, 16'h4174);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/channel_config_sequencer.md
CHANNEL_CONFIG_SEQUENCER -- requirements
Module: channel_config_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 1023: max cycles waiting for Cmd_done per command before abort.
REQ-002 Parameter FREQ_BASE, default 357: FREQ code for Channel 0.
REQ-003 Clock  input  1  sole clock; all logic on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 ChannelChange  input  1  level request from channel-change FSM; held until ChannelChange_done.
REQ-006 Channel  input  4  requested channel index 0..15.
REQ-007 ChannelChange_done  output  1  one-cycle pulse: sequence finished (success or abort).
REQ-008 Busy  output  1  high whenever state is not IDLE.
REQ-009 Error  output  1  sticky; set on timeout abort, cleared by Reset or next successful sequence.
REQ-010 Cmd_valid  output  1  radio command request.
REQ-011 Cmd_isStrobe  output  1  1 = strobe (address only), 0 = register write.
REQ-012 Cmd_addr  output  6  register/strobe address.
REQ-013 Cmd_data  output  16  write data; 16'h0000 for strobes.
REQ-014 Cmd_ready  input  1  radio port accepts the command this cycle.
REQ-015 Cmd_done  input  1  one-cycle pulse: accepted command completed.

Function
REQ-016 Sequence SHALL start on rising edge of ChannelChange (registered previous value) while in IDLE.
REQ-017 On start, Channel SHALL be latched; later Channel changes SHALL NOT affect the running sequence.
REQ-018 FREQ SHALL be 10-bit FREQ_BASE + 5*latched Channel (range 357..432, no overflow); write data = {6'b010000, FREQ}.
REQ-019 Command order: strobe SRFOFF (addr 6'h06), write FSCTRL (addr 6'h18, data per REQ-018), strobe SRXON (addr 6'h03).
REQ-020 States: IDLE, ISSUE, WAIT_DONE, NEXT, FINISH; ISSUE asserts Cmd_valid with stable Cmd_isStrobe/addr/data until the cycle Cmd_ready=1, then WAIT_DONE.
REQ-021 Cmd_valid SHALL drop the cycle after acceptance; a new command SHALL be issued no earlier than one cycle after Cmd_done.
REQ-022 Cmd_done received outside WAIT_DONE SHALL be ignored.
REQ-023 WAIT_DONE counter SHALL count cycles from acceptance; reaching TIMEOUT without Cmd_done SHALL set Error, skip remaining commands, go to FINISH.
REQ-024 No timeout SHALL apply in ISSUE (Cmd_ready may stall indefinitely).
REQ-025 FINISH SHALL pulse ChannelChange_done for exactly one cycle, then return to IDLE; success clears Error in that cycle.
REQ-026 A rising edge of ChannelChange while Busy SHALL set a Pending flag; on returning to IDLE with Pending set, a new sequence SHALL start next cycle, latching Channel at that point.
REQ-027 Rising edge and FINISH in the same cycle SHALL set Pending (not lost).
REQ-028 Latency with Cmd_ready and Cmd_done returned 1 cycle after each request/accept: sequence start to ChannelChange_done pulse SHALL be fixed and documented in the bench (one ISSUE+WAIT_DONE+NEXT per command plus FINISH).

Reset
REQ-029 Reset SHALL force IDLE; outputs Cmd_valid=0, Cmd_isStrobe=0, Cmd_addr=0, Cmd_data=0, ChannelChange_done=0, Busy=0, Error=0; Pending, counter, edge register cleared.
REQ-030 Reset mid-sequence SHALL abort with no ChannelChange_done pulse; a level-high ChannelChange after Reset SHALL NOT start a sequence until it falls and rises again.

Structure
REQ-031 Shared package SHALL hold state encoding, strobe/register addresses (SRFOFF, SRXON, FSCTRL), FSCTRL upper-bits constant 6'b010000, FREQ step 5.
REQ-032 One sub-module radio_cmd_issuer SHALL own the valid/ready/done handshake and timeout counter; the sequencer supplies command fields and start, receives done/timeout.

Verification
REQ-033 Channel=4'b1001, rising ChannelChange, immediate ready/done -> commands (strobe 06), (write 18, 16'h4192), (strobe 03); one done pulse; Error=0.
REQ-034 Channel=0 then 15 -> write data 16'h4165 and 16'h41B0 respectively.
REQ-035 Cmd_ready held low 50 cycles -> Cmd_valid and fields stable all 50 cycles; no Error.
REQ-036 Cmd_done withheld after FSCTRL accept, TIMEOUT=16 -> Error=1 after 16 cycles, SRXON never issued, one done pulse.
REQ-037 Second ChannelChange rising edge with Channel=4'b0011 mid-sequence -> after first done pulse, second sequence writes 16'h4174.
REQ-038 Reset asserted during WAIT_DONE -> all outputs zero next cycle, no done pulse, held-high ChannelChange ignored.
